piso_serializer: RTL

- Parallel-in, serial-out transmitter: the sending end for the team's serial-in, left-shifting register (shift_left_register).
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clk, with a qualifying enable.
- Wiring sout to the receiver's serial input and sout_en to its enable leaves the original word in the receiver's Q after the frame.

---
 rtl/piso_serializer.sv | 95 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, MSB first, with valid/ready load.
// Define PIS_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PIS_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
`ifdef PIS_PARITY_EN
  logic             par_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
`ifdef PIS_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= din;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
`ifdef PIS_PARITY_EN
            par_q <= ^din;
`endif
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
`ifdef PIS_PARITY_EN
            state  <= PARITY;
`else
            state  <= IDLE;
            done_q <= 1'b1;
`endif
          end
        end
`ifdef PIS_PARITY_EN
        PARITY: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    sout = 1'b0;
    unique case (1'b1)
      (state == SHIFT): sout = shreg[WIDTH-1];
`ifdef PIS_PARITY_EN
      (state == PARITY): sout = par_q;
`endif
      default: sout = 1'b0;
    endcase
  end

  assign sout_en    = (state != IDLE);
  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE);
  assign done       = done_q;

endmodule
